// File: rtl/spi_seq_pkg.sv
// Shared types and helpers for the SPI frame sequencer.
package spi_seq_pkg;

  localparam int unsigned ByteW = 8;

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StAck,
    StGap,
    StDone,
    StErr
  } state_e;

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, synchronous reset to zero.
module sync_2ff #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/spi_frame_sequencer.sv
// Feeds a multi-byte frame to the byte-wide SPI transmitter, most significant byte first,
// with an inter-byte gap and a handshake timeout.
module spi_frame_sequencer
  import spi_seq_pkg::*;
#(
  parameter int unsigned NUM_BYTES   = 4,
  parameter int unsigned GAP_CYC     = 100,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter int unsigned LEN_W       = $clog2(NUM_BYTES + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ByteW*NUM_BYTES-1:0] frame_data,
  input  logic [LEN_W-1:0]           frame_len,
  output logic                       ready,
  output logic                       frame_done,
  output logic                       timeout_err,
  output logic                       spi_send,
  output logic [ByteW-1:0]           spi_data_out,
  output logic                       spi_busy,
  input  logic                       spi_send_done
);

  localparam int unsigned DataW = ByteW * NUM_BYTES;
  localparam int unsigned TmrW  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned GapW  = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;

  state_e           state_q, state_d;
  logic [DataW-1:0] shadow_q, shadow_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [TmrW-1:0]  tmr_q, tmr_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic             terr_q, terr_d;
  logic             done_s;
  logic [LEN_W-1:0] len_clamped;
  logic [LEN_W-1:0] byte_idx;
  logic [ByteW-1:0] cur_byte;
  logic             tmr_expired;

  sync_2ff #(
    .Width(1)
  ) u_done_sync (
    .clk(clk),
    .rst(rst),
    .d  (spi_send_done),
    .q  (done_s)
  );

  assign len_clamped = LEN_W'(clamp_len(32'(frame_len), NUM_BYTES));
  assign byte_idx    = remaining_q - 1'b1;
  assign tmr_expired = (tmr_q == TmrW'(TIMEOUT_CYC - 1));
  assign timeout_err = terr_q;

  always_comb begin
    cur_byte = '0;
    for (int unsigned k = 0; k < NUM_BYTES; k++) begin
      if (LEN_W'(k) == byte_idx) cur_byte = shadow_q[k*ByteW +: ByteW];
    end
  end

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    remaining_d  = remaining_q;
    terr_d       = terr_q;
    ready        = 1'b0;
    frame_done   = 1'b0;
    spi_send     = 1'b0;
    spi_busy     = 1'b0;
    spi_data_out = '0;

    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (start) begin
          shadow_d    = frame_data;
          remaining_d = len_clamped;
          terr_d      = 1'b0;
          state_d     = (len_clamped == '0) ? StDone : StSend;
        end
      end
      StSend: begin
        spi_send     = 1'b1;
        spi_data_out = cur_byte;
        if (done_s) begin
          state_d     = StAck;
          remaining_d = remaining_q - 1'b1;
        end else if (tmr_expired) begin
          state_d = StErr;
          terr_d  = 1'b1;
        end
      end
      StAck: begin
        spi_busy = 1'b1;
        if (!done_s) begin
          if (remaining_q == '0) state_d = StDone;
          else state_d = (GAP_CYC == 0) ? StSend : StGap;
        end else if (tmr_expired) begin
          state_d = StErr;
          terr_d  = 1'b1;
        end
      end
      StGap: begin
        if (GAP_CYC == 0 || gap_q == GapW'(GAP_CYC - 1)) state_d = StSend;
      end
      StDone: begin
        frame_done = 1'b1;
        state_d    = StIdle;
      end
      StErr: begin
        // Busy releases a transmitter that may be parked in FINISH.
        spi_busy = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Both counters restart on every state change.
    tmr_d = '0;
    if (state_d == state_q && (state_q == StSend || state_q == StAck)) tmr_d = tmr_q + 1'b1;
    gap_d = '0;
    if (state_d == state_q && state_q == StGap) gap_d = gap_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      shadow_q    <= '0;
      remaining_q <= '0;
      tmr_q       <= '0;
      gap_q       <= '0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      remaining_q <= remaining_d;
      tmr_q       <= tmr_d;
      gap_q       <= gap_d;
      terr_q      <= terr_d;
    end
  end

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Bench: two sequencers (gap 10 and gap 0) against a behavioural transmitter and frame model.
module tb_spi_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  start;
  logic [31:0] frame_data;
  logic [2:0]  frame_len;
  logic [1:0]  ready, frame_done, timeout_err, spi_send, spi_busy, spi_send_done;
  logic [7:0]  data_out [2];

  always #5 clk = ~clk;

  spi_frame_sequencer #(
    .NUM_BYTES(4), .GAP_CYC(10), .TIMEOUT_CYC(50), .LEN_W(3)
  ) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .frame_data(frame_data), .frame_len(frame_len),
    .ready(ready[0]), .frame_done(frame_done[0]), .timeout_err(timeout_err[0]),
    .spi_send(spi_send[0]), .spi_data_out(data_out[0]), .spi_busy(spi_busy[0]),
    .spi_send_done(spi_send_done[0])
  );

  spi_frame_sequencer #(
    .NUM_BYTES(4), .GAP_CYC(0), .TIMEOUT_CYC(50), .LEN_W(3)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .frame_data(frame_data), .frame_len(frame_len),
    .ready(ready[1]), .frame_done(frame_done[1]), .timeout_err(timeout_err[1]),
    .spi_send(spi_send[1]), .spi_data_out(data_out[1]), .spi_busy(spi_busy[1]),
    .spi_send_done(spi_send_done[1])
  );

  // Transmitter model: 3 cycles of shifting, then FINISH until busy is seen.
  logic [1:0] tx_done;
  int         tx_cnt [2];
  bit         tx_mute, tx_stuck;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        tx_done[k] <= 1'b0;
        tx_cnt[k]  <= 0;
      end else if (!tx_done[k]) begin
        if (spi_send[k] && !tx_mute) begin
          if (tx_cnt[k] == 2) begin
            tx_done[k] <= 1'b1;
            tx_cnt[k]  <= 0;
          end else tx_cnt[k] <= tx_cnt[k] + 1;
        end else tx_cnt[k] <= 0;
      end else if (spi_busy[k]) tx_done[k] <= 1'b0;
    end
  end

  assign spi_send_done = tx_stuck ? 2'b11 : tx_done;

  // Monitor, sampled on the falling edge.
  int          cyc = 0;
  logic [1:0]  prev_send = '0, prev_busy = '0;
  logic [31:0] obs_seq [2];
  int          obs_n [2], done_cnt [2], t_done [2], gap_first [2], gap_len [2], t_send [2];
  int          busy_lat [2];
  bit          gap_meas [2], gap_got [2], unstable [2];
  logic [7:0]  held [2];

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (frame_done[k]) begin
        done_cnt[k]++;
        if (done_cnt[k] == 1) t_done[k] = cyc;
      end
      if (spi_send[k] && !prev_send[k]) begin
        obs_seq[k] = (obs_seq[k] << 8) | {24'h0, data_out[k]};
        obs_n[k]++;
        held[k]   = data_out[k];
        t_send[k] = cyc;
      end else if (spi_send[k] && data_out[k] != held[k]) unstable[k] = 1'b1;
      if (spi_busy[k] && !prev_busy[k]) busy_lat[k] = cyc - t_send[k];
      if (!spi_busy[k] && prev_busy[k]) begin
        gap_meas[k] = 1'b1;
        gap_len[k]  = 0;
      end
      if (gap_meas[k]) begin
        if (spi_send[k]) begin
          if (!gap_got[k]) begin
            gap_first[k] = gap_len[k];
            gap_got[k]   = 1'b1;
          end
          gap_meas[k] = 1'b0;
        end else gap_len[k]++;
      end
    end
    prev_send = spi_send;
    prev_busy = spi_busy;
  end

  int n_chk = 0, n_fail = 0;
  int t_start;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    for (int k = 0; k < 2; k++) begin
      obs_seq[k] = '0; obs_n[k] = 0; done_cnt[k] = 0; t_done[k] = -1;
      gap_first[k] = -1; gap_meas[k] = 0; gap_got[k] = 0; unstable[k] = 0; busy_lat[k] = -1;
    end
  endtask

  // Reference: min(len, 4) bytes, highest index first.
  function automatic void ref_frame(input logic [31:0] d, input int len, output int n,
                                    output logic [31:0] seq);
    n   = (len > 4) ? 4 : len;
    seq = '0;
    for (int b = n - 1; b >= 0; b--) seq = (seq << 8) | ((d >> (8 * b)) & 32'hFF);
  endfunction

  task automatic start_frame(input int k, input int len, input logic [31:0] d);
    @(posedge clk); #1;
    clear_mon();
    frame_len  = 3'(len);
    frame_data = d;
    start[k]   = 1'b1;
    t_start    = cyc;
    @(posedge clk); #1;
    start[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ready[k]) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    int          len;
    logic [31:0] data;
    int          exp_n;
    logic [31:0] exp_seq;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    int          n;
    logic [31:0] seq, d;
    int          len;

    vecs[0] = '{4, 32'hA1B2C3D4, 4, 32'hA1B2C3D4};
    vecs[1] = '{7, 32'h11223344, 4, 32'h11223344};
    vecs[2] = '{0, 32'hDEADBEEF, 0, 32'h00000000};
    vecs[3] = '{2, 32'hDEADBEEF, 2, 32'h0000BEEF};
    vecs[4] = '{3, 32'h01020304, 3, 32'h00020304};
    vecs[5] = '{1, 32'h55667788, 1, 32'h00000088};
    vecs[6] = '{5, 32'hCAFEF00D, 4, 32'hCAFEF00D};

    rst = 1'b1; start = '0; frame_data = '0; frame_len = '0; tx_mute = 0; tx_stuck = 0;
    clear_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", ready, 2'b11);
    check("rst_frame_done", frame_done, 2'b00);
    check("rst_timeout_err", timeout_err, 2'b00);
    check("rst_spi_send", spi_send, 2'b00);
    check("rst_spi_busy", spi_busy, 2'b00);
    check("rst_data_out", data_out[0], 8'h00);
    rst = 1'b0;

    // Table of frames on the gapped instance.
    for (int i = 0; i < 7; i++) begin
      start_frame(0, vecs[i].len, vecs[i].data);
      wait_idle(0, 600, ok);
      check($sformatf("tbl%0d_idle", i), ok, 1);
      check($sformatf("tbl%0d_nbytes", i), obs_n[0], vecs[i].exp_n);
      check($sformatf("tbl%0d_seq", i), obs_seq[0], vecs[i].exp_seq);
      check($sformatf("tbl%0d_done", i), done_cnt[0], 1);
      check($sformatf("tbl%0d_terr", i), timeout_err[0], 0);
      check($sformatf("tbl%0d_stable", i), unstable[0], 0);
      if (vecs[i].exp_n >= 2) check($sformatf("tbl%0d_gap", i), gap_first[0], 10);
      if (vecs[i].exp_n == 0) check($sformatf("tbl%0d_done_lat", i), t_done[0] - t_start, 2);
    end

    // Back-to-back instance.
    start_frame(1, 4, 32'h0F1E2D3C);
    wait_idle(1, 600, ok);
    check("gap0_idle", ok, 1);
    check("gap0_seq", obs_seq[1], 32'h0F1E2D3C);
    check("gap0_gap", gap_first[1], 0);
    check("gap0_done", done_cnt[1], 1);

    // Transmitter never answers.
    tx_mute = 1;
    start_frame(0, 2, 32'h0000ABCD);
    wait_idle(0, 300, ok);
    check("to_idle", ok, 1);
    check("to_latency", busy_lat[0], 50);
    check("to_terr", timeout_err[0], 1);
    check("to_ready", ready[0], 1);
    check("to_send_low", spi_send[0], 0);
    check("to_no_done", done_cnt[0], 0);
    check("to_nbytes", obs_n[0], 1);
    tx_mute = 0;
    start_frame(0, 1, 32'h00000099);
    check("to_terr_clear", timeout_err[0], 0);
    wait_idle(0, 300, ok);
    check("to_next_seq", obs_seq[0], 32'h99);

    // Start during the second byte must be ignored.
    start_frame(0, 4, 32'h10203040);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (obs_n[0] == 2) begin
        ok = 1;
        break;
      end
    end
    check("ign_reach_byte2", ok, 1);
    frame_data = 32'hFFFFFFFF; frame_len = 3'd1; start[0] = 1'b1;
    repeat (5) @(negedge clk);
    start[0] = 1'b0;
    wait_idle(0, 600, ok);
    check("ign_seq", obs_seq[0], 32'h10203040);
    check("ign_nbytes", obs_n[0], 4);
    check("ign_done", done_cnt[0], 1);

    // Reset during ACK of the first byte.
    start_frame(0, 3, 32'h0A0B0C0D);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (spi_busy[0] && obs_n[0] == 1) begin
        ok = 1;
        break;
      end
    end
    check("rstmid_reach_ack", ok, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_send", spi_send[0], 0);
    check("rstmid_busy", spi_busy[0], 0);
    check("rstmid_ready", ready[0], 1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid_no_done", done_cnt[0], 0);
    start_frame(0, 4, 32'hA1B2C3D4);
    wait_idle(0, 600, ok);
    check("rstmid_next_seq", obs_seq[0], 32'hA1B2C3D4);
    check("rstmid_next_done", done_cnt[0], 1);

    // Stale FINISH: done held high must end in a timeout, not a hang.
    tx_stuck = 1;
    repeat (4) @(negedge clk);
    start_frame(0, 2, 32'h00005A5A);
    wait_idle(0, 400, ok);
    check("stale_idle", ok, 1);
    check("stale_terr", timeout_err[0], 1);
    check("stale_no_done", done_cnt[0], 0);
    tx_stuck = 0;
    repeat (6) @(negedge clk);

    // Random frames against the reference model.
    for (int i = 0; i < 12; i++) begin
      len = int'($urandom_range(0, 7));
      d   = $urandom;
      ref_frame(d, len, n, seq);
      start_frame(0, len, d);
      wait_idle(0, 600, ok);
      check($sformatf("rnd%0d_idle", i), ok, 1);
      check($sformatf("rnd%0d_nbytes", i), obs_n[0], n);
      check($sformatf("rnd%0d_seq", i), obs_seq[0], seq);
      check($sformatf("rnd%0d_done", i), done_cnt[0], 1);
      check($sformatf("rnd%0d_terr", i), timeout_err[0], 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
